// File: rtl/cpri_tx_pack.sv
// CPRI TX loop-buffer write stage: packs one header-tagged packet of PAY_LEN payload words
// into a buffer packet laid out as header(0,1), checksum(2), payload(3..), committing on the checksum write.
`timescale 1ns/1ps
module cpri_tx_pack #(
   parameter logic [15:0] SYNC_WORD = 16'hA5C3,
   parameter int          PAY_LEN   = 93,
   parameter int          ADDR_W    = 7,
   parameter int          CNT_W     = 16
) (
   input  logic              wr_clk,
   input  logic              wr_rst,
   input  logic              i_pkt_start,
   input  logic [6:0]        i_slot_idx,
   input  logic [3:0]        i_symb_idx,
   input  logic [7:0]        i_ant_grp,
   input  logic [63:0]       i_hdr_info,
   output logic              o_start_rdy,
   input  logic              i_buf_afull,
   input  logic              i_valid,
   input  logic [63:0]       i_data,
   output logic              o_ready,
   output logic              o_cpri_wen,
   output logic [ADDR_W-1:0] o_cpri_waddr,
   output logic [63:0]       o_cpri_wdata,
   output logic              o_cpri_wlast,
   output logic [CNT_W-1:0]  o_drop_cnt,
   output logic [CNT_W-1:0]  o_abort_cnt
);

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAY, CSUM} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PAY_LEN - 1);
   localparam logic [ADDR_W-1:0] PAY_BASE = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] CSUM_ADR = ADDR_W'(2);

   state_t              state_q, state_d;
   logic [6:0]          slot_q, slot_d;
   logic [3:0]          symb_q, symb_d;
   logic [7:0]          ant_q, ant_d;
   logic [63:0]         info_q, info_d;
   logic [CNT_W-1:0]    seq_q, seq_d;
   logic [63:0]         csum_q, csum_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]    drop_q, drop_d;
   logic [CNT_W-1:0]    abort_q, abort_d;
   logic                wen_q, wen_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [63:0]         wdata_q, wdata_d;
   logic                wlast_q, wlast_d;
   logic                latch;

   // Gated by reset so nothing looks ready while the block is held in reset.
   assign o_start_rdy = (state_q == IDLE) && !i_buf_afull && !wr_rst;
   assign o_ready     = (state_q == PAY);

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      symb_d  = symb_q;
      ant_d   = ant_q;
      info_d  = info_q;
      seq_d   = seq_q;
      csum_d  = csum_q;
      idx_d   = idx_q;
      drop_d  = drop_q;
      abort_d = abort_q;
      wen_d   = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
      wlast_d = 1'b0;
      latch   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_pkt_start) begin
               if (o_start_rdy) begin
                  latch   = 1'b1;
                  state_d = HDR0;
               end else if (drop_q != '1) begin
                  drop_d = drop_q + 1'b1;
               end
            end
         end
         HDR0, HDR1, PAY: begin
            if (i_pkt_start) begin
               // Abort: nothing is written this cycle and the buffer reuses the addresses.
               latch   = 1'b1;
               state_d = HDR0;
               if (abort_q != '1) abort_d = abort_q + 1'b1;
            end else if (state_q == HDR0) begin
               wen_d   = 1'b1;
               waddr_d = '0;
               wdata_d = {SYNC_WORD, 16'(seq_q), 1'b0, slot_q, 4'b0, symb_q, ant_q, 8'(PAY_LEN)};
               state_d = HDR1;
            end else if (state_q == HDR1) begin
               wen_d   = 1'b1;
               waddr_d = ADDR_W'(1);
               wdata_d = info_q;
               idx_d   = '0;
               state_d = PAY;
            end else if (i_valid) begin
               wen_d   = 1'b1;
               waddr_d = PAY_BASE + idx_q;
               wdata_d = i_data;
               csum_d  = csum_q ^ i_data;
               idx_d   = idx_q + 1'b1;
               if (idx_q == LAST_IDX) state_d = CSUM;
            end
         end
         CSUM: begin
            wen_d   = 1'b1;
            waddr_d = CSUM_ADR;
            wdata_d = csum_q;
            wlast_d = 1'b1;
            seq_d   = seq_q + 1'b1;
            // A start here is a fresh packet, not an abort; the commit above still happens.
            if (i_pkt_start) begin
               latch   = 1'b1;
               state_d = HDR0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (latch) begin
         slot_d = i_slot_idx;
         symb_d = i_symb_idx;
         ant_d  = i_ant_grp;
         info_d = i_hdr_info;
         csum_d = '0;
      end
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         state_q <= IDLE;
         slot_q  <= '0;
         symb_q  <= '0;
         ant_q   <= '0;
         info_q  <= '0;
         seq_q   <= '0;
         csum_q  <= '0;
         idx_q   <= '0;
         drop_q  <= '0;
         abort_q <= '0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         wlast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         symb_q  <= symb_d;
         ant_q   <= ant_d;
         info_q  <= info_d;
         seq_q   <= seq_d;
         csum_q  <= csum_d;
         idx_q   <= idx_d;
         drop_q  <= drop_d;
         abort_q <= abort_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         wlast_q <= wlast_d;
      end
   end

   assign o_cpri_wen   = wen_q;
   assign o_cpri_waddr = waddr_q;
   assign o_cpri_wdata = wdata_q;
   assign o_cpri_wlast = wlast_q;
   assign o_drop_cnt   = drop_q;
   assign o_abort_cnt  = abort_q;

endmodule

// File: tb/tb_cpri_tx_pack.sv
// Bench for cpri_tx_pack: a queue of expected buffer writes is built from the packet layout rules
// and every DUT write is popped and compared in order.
`timescale 1ns/1ps
module tb_cpri_tx_pack;
   logic        wr_clk = 1'b0, wr_rst = 1'b1;
   logic        i_pkt_start = 0, i_buf_afull = 0, i_valid = 0;
   logic [6:0]  i_slot_idx = 0;
   logic [3:0]  i_symb_idx = 0;
   logic [7:0]  i_ant_grp = 0;
   logic [63:0] i_hdr_info = 0, i_data = 0;
   logic        o_start_rdy, o_ready, o_cpri_wen, o_cpri_wlast;
   logic [6:0]  o_cpri_waddr;
   logic [63:0] o_cpri_wdata;
   logic [15:0] o_drop_cnt, o_abort_cnt;

   cpri_tx_pack dut (
      .wr_clk(wr_clk), .wr_rst(wr_rst), .i_pkt_start(i_pkt_start), .i_slot_idx(i_slot_idx),
      .i_symb_idx(i_symb_idx), .i_ant_grp(i_ant_grp), .i_hdr_info(i_hdr_info),
      .o_start_rdy(o_start_rdy), .i_buf_afull(i_buf_afull), .i_valid(i_valid), .i_data(i_data),
      .o_ready(o_ready), .o_cpri_wen(o_cpri_wen), .o_cpri_waddr(o_cpri_waddr),
      .o_cpri_wdata(o_cpri_wdata), .o_cpri_wlast(o_cpri_wlast), .o_drop_cnt(o_drop_cnt),
      .o_abort_cnt(o_abort_cnt));

   always #5 wr_clk = ~wr_clk;

   typedef struct packed {logic [6:0] addr; logic [63:0] data; logic last;} wr_t;
   wr_t         exp_q[$];
   int          vec = 0, mis = 0;
   int          cyc = 0, nwr = 0, nlast = 0, first_cyc = -1, last_cyc = 0;
   logic [63:0] mem [128];
   logic [63:0] pay [93];
   logic [15:0] seq = 0;

   always @(posedge wr_clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Write monitor: every write must match the head of the expected queue.
   always @(negedge wr_clk) begin
      if (!wr_rst && o_cpri_wen) begin
         nwr++;
         if (o_cpri_wlast) nlast++;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
         mem[o_cpri_waddr] = o_cpri_wdata;
         vec++;
         assert (exp_q.size() != 0) else begin
            mis++;
            $error("FAIL unexpected_write observed=addr %0d expected=no write", o_cpri_waddr);
         end
         if (exp_q.size() != 0) begin
            wr_t e;
            e = exp_q.pop_front();
            chk("waddr", 64'(o_cpri_waddr), 64'(e.addr));
            chk("wdata", o_cpri_wdata, e.data);
            chk("wlast", 64'(o_cpri_wlast), 64'(e.last));
         end
      end
   end

   // Reference: header, payload in index order, then checksum as the committing write.
   task automatic expect_pkt(input logic [6:0] s, input logic [3:0] y, input logic [7:0] a,
                             input logic [63:0] info, input int nb, input bit done);
      logic [63:0] x = 0;
      exp_q.push_back({7'd0, {16'hA5C3, seq, 1'b0, s, 4'b0, y, a, 8'd93}, 1'b0});
      exp_q.push_back({7'd1, info, 1'b0});
      for (int k = 0; k < nb; k++) begin
         exp_q.push_back({7'(3 + k), pay[k], 1'b0});
         x ^= pay[k];
      end
      if (done) begin
         exp_q.push_back({7'd2, x, 1'b1});
         seq++;
      end
   endtask

   task automatic start(input logic [6:0] s, input logic [3:0] y, input logic [7:0] a,
                        input logic [63:0] info, input bit with_valid);
      @(negedge wr_clk);
      i_pkt_start = 1; i_slot_idx = s; i_symb_idx = y; i_ant_grp = a; i_hdr_info = info;
      i_valid = with_valid; i_data = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge wr_clk);
      i_pkt_start = 0; i_valid = 0;
   endtask

   // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
   task automatic send_beats(input int n, input int mode);
      int k = 0, b = 0;
      bit acc;
      while (k < n && b < 2000) begin
         @(negedge wr_clk);
         i_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((b % 2) == 1) : 1'($urandom_range(0, 1));
         i_data  = pay[k];
         acc = i_valid && o_ready;
         @(posedge wr_clk);
         if (acc) k++;
         b++;
      end
      #1 i_valid = 0;
      chk("beat_budget", 64'(k), 64'(n));
   endtask

   task automatic drain();
      int b = 0;
      while (exp_q.size() != 0 && b < 300) begin
         @(negedge wr_clk);
         b++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic win();
      nwr = 0; nlast = 0; first_cyc = -1;
   endtask

   task automatic rand_pay();
      for (int k = 0; k < 93; k++) pay[k] = {$urandom, $urandom};
   endtask

   logic [6:0]  s;
   logic [3:0]  y;
   logic [7:0]  a;
   logic [63:0] info;

   task automatic rand_hdr();
      s = 7'($urandom_range(0, 79)); y = 4'($urandom_range(0, 13));
      a = 8'($urandom); info = {$urandom, $urandom};
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge wr_clk);
      chk("rst_start_rdy", 64'(o_start_rdy), 0);
      chk("rst_ready", 64'(o_ready), 0);
      chk("rst_wen", 64'(o_cpri_wen), 0);
      chk("rst_drop", 64'(o_drop_cnt), 0);
      chk("rst_abort", 64'(o_abort_cnt), 0);
      wr_rst = 0;
      #1 chk("rel_start_rdy", 64'(o_start_rdy), 1);

      // 1: back-to-back packet, data = k
      for (int k = 0; k < 93; k++) pay[k] = 64'(k);
      win();
      expect_pkt(7'd5, 4'd3, 8'd2, 64'h0123_4567_89AB_CDEF, 93, 1);
      start(7'd5, 4'd3, 8'd2, 64'h0123_4567_89AB_CDEF, 0);
      send_beats(93, 0);
      drain();
      chk("t1_nwr", 64'(nwr), 96);
      chk("t1_span", 64'(last_cyc - first_cyc), 95);
      chk("t1_word0", mem[0], 64'hA5C3_0000_0503_025D);
      chk("t1_csum", mem[2], 64'h5C);
      chk("t1_nlast", 64'(nlast), 1);

      // 2: same packet with alternate gaps
      win();
      expect_pkt(7'd5, 4'd3, 8'd2, 64'h0123_4567_89AB_CDEF, 93, 1);
      start(7'd5, 4'd3, 8'd2, 64'h0123_4567_89AB_CDEF, 0);
      send_beats(93, 1);
      drain();
      chk("t2_nwr", 64'(nwr), 96);
      chk("t2_gapped", 64'(last_cyc - first_cyc > 95), 1);
      chk("t2_word0", mem[0], 64'hA5C3_0001_0503_025D);

      // 3: almost-full refuses the start
      win();
      i_buf_afull = 1;
      @(negedge wr_clk);
      chk("t3_start_rdy", 64'(o_start_rdy), 0);
      start(7'd1, 4'd1, 8'd1, 64'h1, 0);
      repeat (4) @(negedge wr_clk);
      chk("t3_drop", 64'(o_drop_cnt), 1);
      chk("t3_nwr", 64'(nwr), 0);
      i_buf_afull = 0;
      rand_pay(); rand_hdr();
      expect_pkt(s, y, a, info, 93, 1);
      start(s, y, a, info, 0);
      send_beats(93, 2);
      drain();

      // 4: abort after 40 beats; a beat coincident with the abort is dropped
      win();
      rand_pay(); rand_hdr();
      expect_pkt(s, y, a, info, 40, 0);
      start(s, y, a, info, 0);
      send_beats(40, 0);
      rand_pay(); rand_hdr();
      expect_pkt(s, y, a, info, 93, 1);
      start(s, y, a, info, 1);
      send_beats(93, 0);
      drain();
      chk("t4_abort", 64'(o_abort_cnt), 1);
      chk("t4_nlast", 64'(nlast), 1);

      // 5: start landing in the checksum cycle
      win();
      rand_pay(); rand_hdr();
      expect_pkt(s, y, a, info, 93, 1);
      start(s, y, a, info, 0);
      send_beats(93, 0);
      expect_pkt(s, y, a, info, 93, 1);
      start(s, y, a, info, 0);
      send_beats(93, 0);
      drain();
      chk("t5_abort", 64'(o_abort_cnt), 1);
      chk("t5_nlast", 64'(nlast), 2);

      // 6: reset mid-payload
      rand_pay(); rand_hdr();
      expect_pkt(s, y, a, info, 20, 0);
      start(s, y, a, info, 0);
      send_beats(20, 0);
      @(negedge wr_clk);
      #2 wr_rst = 1;
      #1;
      chk("t6_start_rdy", 64'(o_start_rdy), 0);
      chk("t6_ready", 64'(o_ready), 0);
      chk("t6_wen", 64'(o_cpri_wen), 0);
      chk("t6_waddr", 64'(o_cpri_waddr), 0);
      chk("t6_wdata", o_cpri_wdata, 0);
      chk("t6_wlast", 64'(o_cpri_wlast), 0);
      chk("t6_drop", 64'(o_drop_cnt), 0);
      chk("t6_abort", 64'(o_abort_cnt), 0);
      chk("t6_partial", 64'(exp_q.size()), 0);
      seq = 0;
      repeat (2) @(negedge wr_clk);
      wr_rst = 0;
      #1 chk("t6_rel_rdy", 64'(o_start_rdy), 1);
      win();
      rand_pay(); rand_hdr();
      expect_pkt(s, y, a, info, 93, 1);
      start(s, y, a, info, 0);
      send_beats(93, 0);
      drain();
      chk("t6_seq", 64'(mem[0][47:32]), 0);

      // 7: random packets with random gaps
      for (int p = 0; p < 3; p++) begin
         rand_pay(); rand_hdr();
         expect_pkt(s, y, a, info, 93, 1);
         start(s, y, a, info, 0);
         send_beats(93, 2);
         drain();
      end

      repeat (4) @(negedge wr_clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end
endmodule
